// File: rtl/interrupt_arbiter.sv
// -----------------------------------------------------------------------------
// interrupt_arbiter
//
// Collects completion events from four peripheral "done" lines and keeps each
// one pending until it is serviced. Pending events are filtered by a
// software-written enable mask. A round-robin search picks one winner, which is
// presented to the processor as a single interrupt request with its vector
// address. No new request is issued until the handler returns through JEPC.
//
// Parameters:
//   VEC_BASE    vector address of source 0
//   VEC_STRIDE  address distance between consecutive source vectors
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   synchronous, active-high reset
//   done       in   4   completion levels from sources 0..3 (edge-detected)
//   mask_we    in   1   enable-mask write strobe
//   mask_wd    in   4   new enable mask (bit i enables source i)
//   int_ack    in   1   processor has taken the interrupt (EPC written)
//   iret       in   1   processor executed JEPC
//   interrupt  out  1   request to the processor's interrupt encoder
//   int_addr   out  32  handler vector of the current winner
//   src_id     out  2   index of the current or most recent winner
//   busy       out  1   handler in service
//   pending    out  4   raw pending flags, for diagnosis
// -----------------------------------------------------------------------------
module interrupt_arbiter #(
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  done,
  input  logic        mask_we,
  input  logic [3:0]  mask_wd,
  input  logic        int_ack,
  input  logic        iret,
  output logic        interrupt,
  output logic [31:0] int_addr,
  output logic [1:0]  src_id,
  output logic        busy,
  output logic [3:0]  pending
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  done_q;
  logic [3:0]  mask;
  logic [1:0]  rr_ptr;

  logic [3:0]  rise;
  logic [3:0]  eligible;
  logic [3:0]  clr;
  logic [1:0]  winner;
  logic        win_valid;
  logic [31:0] win_addr;

  assign rise     = done & ~done_q;
  assign eligible = pending & mask;

  // Search upward from rr_ptr; the 2-bit index sum wraps mod 4 on its own.
  // NOTE: every variable written here gets a default first, otherwise paths
  // that skip an assignment would infer a latch.
  always_comb begin
    winner    = '0;
    win_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!win_valid && eligible[rr_ptr + 2'(i)]) begin
        winner    = rr_ptr + 2'(i);
        win_valid = 1'b1;
      end
    end
  end

  assign win_addr = VEC_BASE + (32'(winner) * VEC_STRIDE);

  // The acknowledged source is cleared only while a request is outstanding.
  assign clr = (state == REQ && int_ack) ? (4'b0001 << src_id) : 4'b0000;

  // NOTE: state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, matching real flip-flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      done_q    <= '0;
      pending   <= '0;
      mask      <= 4'hF;
      rr_ptr    <= '0;
      interrupt <= 1'b0;
      int_addr  <= '0;
      src_id    <= '0;
      busy      <= 1'b0;
    end else begin
      done_q <= done;
      // Clear before set: a new edge on the bit being acknowledged survives.
      pending <= (pending & ~clr) | rise;
      if (mask_we) mask <= mask_wd;

      case (state)
        IDLE: begin
          if (win_valid) begin
            src_id    <= winner;
            int_addr  <= win_addr;
            interrupt <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          // Committed request: mask changes and new edges do not disturb it.
          if (int_ack) begin
            interrupt <= 1'b0;
            busy      <= 1'b1;
            state     <= SVC;
          end
        end
        SVC: begin
          if (iret) begin
            busy   <= 1'b0;
            rr_ptr <= src_id + 2'd1;
            state  <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          interrupt <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_interrupt_arbiter
//
// Directed scenarios with hand-computed expectations, followed by randomized
// traffic. A behavioural model (one step per clock edge) tracks the expected
// outputs and a compare process checks the DUT against it on every cycle.
// -----------------------------------------------------------------------------
module tb_interrupt_arbiter;

  localparam logic [31:0] VB = 32'h0000_0100;
  localparam logic [31:0] VS = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  done;
  logic        mask_we;
  logic [3:0]  mask_wd;
  logic        int_ack;
  logic        iret;
  logic        interrupt;
  logic [31:0] int_addr;
  logic [1:0]  src_id;
  logic        busy;
  logic [3:0]  pending;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  interrupt_arbiter #(.VEC_BASE(VB), .VEC_STRIDE(VS)) dut (
    .clk(clk), .reset(reset), .done(done), .mask_we(mask_we), .mask_wd(mask_wd),
    .int_ack(int_ack), .iret(iret), .interrupt(interrupt), .int_addr(int_addr),
    .src_id(src_id), .busy(busy), .pending(pending)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  // mode: 0 = waiting for an event, 1 = request outstanding, 2 = in handler
  typedef struct {
    int        mode;
    bit [3:0]  pend;
    bit [3:0]  msk;
    int        ptr;
    bit [3:0]  prev_done;
    bit        irq;
    bit [31:0] addr;
    int        id;
    bit        bsy;
  } model_t;

  function automatic model_t reset_model();
    model_t r;
    r.mode = 0; r.pend = '0; r.msk = 4'hF; r.ptr = 0; r.prev_done = '0;
    r.irq = 1'b0; r.addr = '0; r.id = 0; r.bsy = 1'b0;
    return r;
  endfunction

  function automatic model_t step(model_t m, bit rst, bit [3:0] d, bit we,
                                  bit [3:0] wd, bit ack, bit ir);
    model_t   n;
    bit [3:0] elig;
    if (rst) return reset_model();
    n = m;
    n.prev_done = d;
    elig = m.pend & m.msk;
    if (we) n.msk = wd;
    if (m.mode == 0 && elig != 0) begin
      for (int k = 0; k < 4; k++) begin
        int idx = (m.ptr + k) % 4;
        if (elig[idx]) begin
          n.id   = idx;
          n.addr = VB + idx * VS;
          n.irq  = 1'b1;
          n.mode = 1;
          break;
        end
      end
    end else if (m.mode == 1 && ack) begin
      n.pend[m.id] = 1'b0;
      n.irq  = 1'b0;
      n.bsy  = 1'b1;
      n.mode = 2;
    end else if (m.mode == 2 && ir) begin
      n.bsy  = 1'b0;
      n.ptr  = (m.id + 1) % 4;
      n.mode = 0;
    end
    // Rising edges are added last so they win over a same-cycle clear.
    n.pend = n.pend | (d & ~m.prev_done);
    return n;
  endfunction

  model_t m = reset_model();

  always @(posedge clk)
    m <= step(m, reset, done, mask_we, mask_wd, int_ack, iret);

  // ---------------------------------------------------------------- checking
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_interrupt", 32'(interrupt), 32'(m.irq));
      check("m_int_addr",  int_addr,       m.addr);
      check("m_src_id",    32'(src_id),    32'(m.id));
      check("m_busy",      32'(busy),      32'(m.bsy));
      check("m_pending",   32'(pending),   32'(m.pend));
    end
  end

  // ---------------------------------------------------------------- stimulus
  // Apply inputs for exactly one rising edge; returns on the following
  // falling edge, when the registered outputs have settled.
  task automatic cyc(input bit [3:0] d, input bit we = 1'b0,
                     input bit [3:0] wd = 4'h0, input bit ack = 1'b0,
                     input bit ir = 1'b0, input bit rst = 1'b0);
    done = d; mask_we = we; mask_wd = wd; int_ack = ack; iret = ir; reset = rst;
    @(negedge clk);
  endtask

  // Wait (bounded) for a request, check its source, then ack and return.
  task automatic serve(input int exp_id);
    int n = 0;
    while (!interrupt && n < 10) begin
      cyc(4'h0);
      n++;
    end
    check("serve_irq", 32'(interrupt), 32'd1);
    check("serve_id", 32'(src_id), 32'(exp_id));
    check("serve_addr", int_addr, VB + 32'(exp_id) * VS);
    cyc(4'h0, .ack(1'b1));
    check("serve_busy", 32'(busy), 32'd1);
    check("serve_irq_lo", 32'(interrupt), 32'd0);
    cyc(4'h0, .ir(1'b1));
    check("serve_ret", 32'(busy), 32'd0);
  endtask

  initial begin
    bit [3:0] lvl;

    cyc(4'h0, .rst(1'b1));
    cyc(4'h0, .rst(1'b1));
    cmp_en = 1'b1;
    check("rst_irq",  32'(interrupt), 32'd0);
    check("rst_addr", int_addr, 32'd0);
    check("rst_id",   32'(src_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pend", 32'(pending), 32'd0);

    // Single source, two-cycle latency.
    cyc(4'b0100);
    check("t1_pend", 32'(pending), 32'h4);
    check("t1_noirq", 32'(interrupt), 32'd0);
    cyc(4'h0);
    check("t1_irq",  32'(interrupt), 32'd1);
    check("t1_addr", int_addr, 32'h120);
    check("t1_id",   32'(src_id), 32'd2);
    check("t1_model_addr", m.addr, 32'h120);
    cyc(4'h0, .ack(1'b1));
    check("t1_ack_irq",  32'(interrupt), 32'd0);
    check("t1_ack_busy", 32'(busy), 32'd1);
    check("t1_ack_pend", 32'(pending), 32'd0);
    cyc(4'h0, .ir(1'b1));
    check("t1_ret_busy", 32'(busy), 32'd0);

    // Round robin from a fresh pointer: 0 then 3, then 0 then 1 after wrap.
    cyc(4'h0, .rst(1'b1));
    cyc(4'b1001);
    cyc(4'h0);
    serve(0);
    serve(3);
    check("t2_model_ptr", 32'(m.ptr), 32'd0);
    cyc(4'b0011);
    cyc(4'h0);
    serve(0);
    serve(1);

    // Masked source stays pending until enabled.
    cyc(4'h0, .we(1'b1), .wd(4'b1110));
    cyc(4'b0001);
    cyc(4'h0);
    cyc(4'h0);
    check("t3_noirq", 32'(interrupt), 32'd0);
    check("t3_pend",  32'(pending), 32'h1);
    cyc(4'h0, .we(1'b1), .wd(4'hF));
    check("t3_wr_noirq", 32'(interrupt), 32'd0);
    cyc(4'h0);
    check("t3_irq",  32'(interrupt), 32'd1);
    check("t3_addr", int_addr, 32'h100);
    serve(0);

    // Re-trigger during service: no nesting, re-request after return.
    cyc(4'b0010);
    cyc(4'h0);
    check("t4_id", 32'(src_id), 32'd1);
    cyc(4'h0, .ack(1'b1));
    cyc(4'b0010);
    cyc(4'h0);
    cyc(4'h0);
    check("t4_noirq", 32'(interrupt), 32'd0);
    check("t4_pend",  32'(pending), 32'h2);
    cyc(4'h0, .ir(1'b1));
    check("t4_ret_noirq", 32'(interrupt), 32'd0);
    cyc(4'h0);
    check("t4_reirq", 32'(interrupt), 32'd1);
    check("t4_addr",  int_addr, 32'h110);
    serve(1);

    // Reset while a request is outstanding.
    cyc(4'b1000);
    cyc(4'h0);
    check("t5_irq", 32'(interrupt), 32'd1);
    cyc(4'h0, .rst(1'b1));
    check("t5_irq0",  32'(interrupt), 32'd0);
    check("t5_addr0", int_addr, 32'd0);
    check("t5_id0",   32'(src_id), 32'd0);
    check("t5_busy0", 32'(busy), 32'd0);
    check("t5_pend0", 32'(pending), 32'd0);
    cyc(4'h0, .ack(1'b1));
    cyc(4'h0, .ir(1'b1));
    cyc(4'h0);
    check("t5_stray_irq",  32'(interrupt), 32'd0);
    check("t5_stray_busy", 32'(busy), 32'd0);

    // Same-cycle set and clear on the acknowledged bit: set wins.
    cyc(4'b0100);
    cyc(4'h0);
    check("t6_id", 32'(src_id), 32'd2);
    cyc(4'b0100, .ack(1'b1));
    check("t6_pend", 32'(pending), 32'h4);
    check("t6_busy", 32'(busy), 32'd1);
    cyc(4'h0, .ir(1'b1));
    serve(2);

    // Randomized traffic; the compare process checks every cycle.
    lvl = 4'h0;
    for (int c = 0; c < 4000; c++) begin
      bit [3:0] flip;
      flip = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      lvl = lvl ^ flip;
      cyc(lvl,
          ($urandom_range(0, 15) == 0),
          4'($urandom_range(0, 15)),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 149) == 0));
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
